rgb_pair_byte_serializer: RTL and testbench

//   Downstream of the image reader / point-operation stage. Consumes the 2-pixel-per-cycle RGB888 stream qualified by HSYNC.

---
 rtl/rgb_pair_byte_serializer_pkg.sv | 36 +++
 rtl/rgb_pair_byte_serializer_if.sv | 25 ++
 rtl/rgb_pair_byte_serializer_pair_sync_fifo.sv | 55 +++++
 rtl/rgb_pair_byte_serializer.sv | 162 ++++++++++++++++
 tb/tb_rgb_pair_byte_serializer.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/rgb_pair_byte_serializer_pkg.sv
// Shared types for the RGB pair byte serializer: FSM states, byte-slot indices
// and the packed pixel-pair layout used between the FIFO and the serializer.
package rgb_pair_byte_serializer_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_EMIT = 1'b1
  } state_t;

  typedef logic [2:0] byte_idx_t;

  // Slot order follows BMP pixel storage: blue, green, red per pixel.
  localparam byte_idx_t IDX_B0 = 3'd0;
  localparam byte_idx_t IDX_G0 = 3'd1;
  localparam byte_idx_t IDX_R0 = 3'd2;
  localparam byte_idx_t IDX_B1 = 3'd3;
  localparam byte_idx_t IDX_G1 = 3'd4;
  localparam byte_idx_t IDX_R1 = 3'd5;

  typedef struct packed {
    logic [7:0] b1;
    logic [7:0] g1;
    logic [7:0] r1;
    logic [7:0] b0;
    logic [7:0] g0;
    logic [7:0] r0;
  } pair_t;

  localparam int PAIR_W = $bits(pair_t);

  // Counter width able to hold 0..n-1, never narrower than one bit.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/rgb_pair_byte_serializer_if.sv
// Byte stream between the serializer (master) and the BMP writer (slave):
// valid/ready handshake with end-of-line / end-of-frame qualifiers.
interface rgb_pair_byte_serializer_if;
  logic [7:0] out_byte;
  logic       out_valid;
  logic       out_ready;
  logic       out_eol;
  logic       out_eof;

  modport master (
    output out_byte,
    output out_valid,
    output out_eol,
    output out_eof,
    input  out_ready
  );

  modport slave (
    input  out_byte,
    input  out_valid,
    input  out_eol,
    input  out_eof,
    output out_ready
  );
endinterface

// File: rtl/rgb_pair_byte_serializer_pair_sync_fifo.sv
// Synchronous FIFO with flush; read data is registered on pop (no fall-through),
// so rd_data doubles as the consumer's holding register.
module pair_sync_fifo #(
  parameter int DATA_W = 48,
  parameter int DEPTH  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = AW + 1;

  logic [DATA_W-1:0] mem [DEPTH];
  logic [AW-1:0]     wr_ptr;
  logic [AW-1:0]     rd_ptr;
  logic [CNT_W-1:0]  count;
  logic              do_rd;
  logic              do_wr;

  assign full  = (count == CNT_W'(DEPTH));
  assign empty = (count == '0);
  assign do_rd = rd_en & ~empty;
  // A pop frees a slot in the same cycle, so a write while full still lands.
  assign do_wr = wr_en & (~full | do_rd);

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      if (do_rd) rd_ptr <= rd_ptr + 1'b1;
      case ({do_wr, do_rd})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_wr && !flush) mem[wr_ptr] <= wr_data;
    if (do_rd && !flush) rd_data <= mem[rd_ptr];
  end

endmodule

// File: rtl/rgb_pair_byte_serializer.sv
// Buffers 2-pixel RGB888 pairs and serializes each into BMP byte order
// (B0,G0,R0,B1,G1,R1) on a valid/ready byte stream with line/frame markers.
module rgb_pair_byte_serializer
  import rgb_pair_byte_serializer_pkg::*;
#(
  parameter int WIDTH      = 1680,
  parameter int HEIGHT     = 1050,
  parameter int FIFO_DEPTH = 16
) (
  input  logic       HCLK,
  input  logic       HRESET,
  input  logic       VSYNC,
  input  logic       HSYNC,
  input  logic [7:0] DATA_R0,
  input  logic [7:0] DATA_G0,
  input  logic [7:0] DATA_B0,
  input  logic [7:0] DATA_R1,
  input  logic [7:0] DATA_G1,
  input  logic [7:0] DATA_B1,
  rgb_pair_byte_serializer_if.master obus,
  output logic       frame_done,
  output logic       overflow,
  output logic       frame_err
);

  localparam int PAIRS_PER_LINE = WIDTH / 2;
  localparam int COL_W          = cnt_w(PAIRS_PER_LINE);
  localparam int ROW_W          = cnt_w(HEIGHT);
  localparam logic [COL_W-1:0] COL_LAST = COL_W'(PAIRS_PER_LINE - 1);
  localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(HEIGHT - 1);

  state_t           state_q, state_d;
  byte_idx_t        idx_q, idx_d;
  logic [COL_W-1:0] col_q;
  logic [ROW_W-1:0] row_q;
  pair_t            wr_pair;
  pair_t            held_pair;
  logic             fifo_full, fifo_empty;
  logic             push_req, pop, drop;
  logic             busy, abort;
  logic             out_valid_w, accept;
  logic             last_byte, line_end, frame_end;
  logic [7:0]       out_byte_w;

  assign wr_pair  = {DATA_B1, DATA_G1, DATA_R1, DATA_B0, DATA_G0, DATA_R0};
  // A pair arriving together with VSYNC belongs to no frame and is discarded.
  assign push_req = HSYNC & ~VSYNC;
  assign drop     = push_req & fifo_full & ~pop;

  assign busy  = ~fifo_empty | (state_q == ST_EMIT) | (row_q != '0) | (col_q != '0);
  assign abort = VSYNC & busy;

  assign out_valid_w = (state_q == ST_EMIT);
  assign accept      = out_valid_w & obus.out_ready;
  assign last_byte   = (idx_q == IDX_R1);
  assign line_end    = last_byte & (col_q == COL_LAST);
  assign frame_end   = line_end & (row_q == ROW_LAST);

  pair_sync_fifo #(
    .DATA_W (PAIR_W),
    .DEPTH  (FIFO_DEPTH)
  ) u_fifo (
    .clk     (HCLK),
    .rst     (HRESET),
    .flush   (abort),
    .wr_en   (push_req),
    .wr_data (wr_pair),
    .rd_en   (pop),
    .rd_data (held_pair),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      state_q <= ST_IDLE;
      idx_q   <= IDX_B0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    pop     = 1'b0;
    if (abort) begin
      state_d = ST_IDLE;
      idx_d   = IDX_B0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            pop     = 1'b1;
            state_d = ST_EMIT;
            idx_d   = IDX_B0;
          end
        end
        ST_EMIT: begin
          if (accept) begin
            if (last_byte) begin
              idx_d = IDX_B0;
              // Chain straight into the next pair so the stream has no bubble.
              if (!fifo_empty) pop = 1'b1;
              else             state_d = ST_IDLE;
            end else begin
              idx_d = idx_q + 3'd1;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_comb begin
    out_byte_w = 8'd0;
    if (out_valid_w) begin
      case (idx_q)
        IDX_B0:  out_byte_w = held_pair.b0;
        IDX_G0:  out_byte_w = held_pair.g0;
        IDX_R0:  out_byte_w = held_pair.r0;
        IDX_B1:  out_byte_w = held_pair.b1;
        IDX_G1:  out_byte_w = held_pair.g1;
        IDX_R1:  out_byte_w = held_pair.r1;
        default: out_byte_w = 8'd0;
      endcase
    end
  end

  assign obus.out_byte  = out_byte_w;
  assign obus.out_valid = out_valid_w;
  assign obus.out_eol   = out_valid_w & line_end;
  assign obus.out_eof   = out_valid_w & frame_end;

  always_ff @(posedge HCLK) begin
    if (HRESET) begin
      col_q      <= '0;
      row_q      <= '0;
      frame_done <= 1'b0;
      overflow   <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      frame_done <= accept & frame_end;
      if (drop) overflow <= 1'b1;
      if (abort) begin
        frame_err <= 1'b1;
        col_q     <= '0;
        row_q     <= '0;
      end else if (accept && last_byte) begin
        if (col_q == COL_LAST) begin
          col_q <= '0;
          row_q <= (row_q == ROW_LAST) ? '0 : row_q + 1'b1;
        end else begin
          col_q <= col_q + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_rgb_pair_byte_serializer.sv
// Directed-sequence bench with randomized pixel data and ready patterns,
// checked against a byte-queue model of BMP ordering and line/frame markers.
module tb_rgb_pair_byte_serializer;

  localparam int WIDTH      = 4;
  localparam int HEIGHT     = 2;
  localparam int FIFO_DEPTH = 4;
  localparam int PPL        = WIDTH / 2;
  localparam int PPF        = PPL * HEIGHT;

  logic       HCLK = 1'b0;
  logic       HRESET = 1'b1;
  logic       VSYNC = 1'b0;
  logic       HSYNC = 1'b0;
  logic [7:0] DATA_R0 = 8'd0, DATA_G0 = 8'd0, DATA_B0 = 8'd0;
  logic [7:0] DATA_R1 = 8'd0, DATA_G1 = 8'd0, DATA_B1 = 8'd0;
  logic       frame_done, overflow, frame_err;

  rgb_pair_byte_serializer_if obus();

  rgb_pair_byte_serializer #(
    .WIDTH      (WIDTH),
    .HEIGHT     (HEIGHT),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) dut (
    .HCLK       (HCLK),
    .HRESET     (HRESET),
    .VSYNC      (VSYNC),
    .HSYNC      (HSYNC),
    .DATA_R0    (DATA_R0),
    .DATA_G0    (DATA_G0),
    .DATA_B0    (DATA_B0),
    .DATA_R1    (DATA_R1),
    .DATA_G1    (DATA_G1),
    .DATA_B1    (DATA_B1),
    .obus       (obus),
    .frame_done (frame_done),
    .overflow   (overflow),
    .frame_err  (frame_err)
  );

  always #5 HCLK = ~HCLK;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int stall_viol = 0;
  int rdy_mode = 1;
  int frame_pair = 0;
  logic [9:0] exp_q[$];
  logic [9:0] rx_q[$];
  int rx_cyc[$];
  int fd_cyc[$];

  always @(posedge HCLK) cyc <= cyc + 1;

  // Consumer ready: 0 = stalled, 1 = always, 2 = pattern 1,0,0,1, else random.
  logic [3:0] ptn = 4'b1001;
  int rcnt = 0;
  always @(posedge HCLK) begin
    #1;
    case (rdy_mode)
      0:       obus.out_ready = 1'b0;
      1:       obus.out_ready = 1'b1;
      2:       obus.out_ready = ptn[rcnt % 4];
      default: obus.out_ready = 1'($urandom_range(1, 0));
    endcase
    rcnt++;
  end

  // Monitor: collects accepted bytes and checks stability under stall.
  logic       pstall = 1'b0;
  logic [9:0] pword = 10'd0;
  always @(negedge HCLK) begin
    if (pstall && !(obus.out_valid === 1'b1 &&
                    {obus.out_eol, obus.out_eof, obus.out_byte} === pword))
      stall_viol++;
    pstall = (obus.out_valid === 1'b1) && (obus.out_ready === 1'b0) && !HRESET && !VSYNC;
    pword  = {obus.out_eol, obus.out_eof, obus.out_byte};
    if (obus.out_valid === 1'b1 && obus.out_ready === 1'b1 && !HRESET) begin
      rx_q.push_back(pword);
      rx_cyc.push_back(cyc);
    end
    if (frame_done === 1'b1) fd_cyc.push_back(cyc);
  end

  initial begin
    #2000000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "simulation time limit reached");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    @(posedge HCLK);
    #1;
  endtask

  task automatic rand_data();
    DATA_R0 = 8'($urandom); DATA_G0 = 8'($urandom); DATA_B0 = 8'($urandom);
    DATA_R1 = 8'($urandom); DATA_G1 = 8'($urandom); DATA_B1 = 8'($urandom);
  endtask

  // Reference: each kept pair contributes six bytes in BMP order; the last
  // byte carries eol when the pair closes a line and eof when it closes a frame.
  task automatic add_pair(input logic [7:0] r0, g0, b0, r1, g1, b1);
    logic [7:0] seq [6];
    bit eol, eof;
    seq = '{b0, g0, r0, b1, g1, r1};
    eol = ((frame_pair % PPL) == PPL - 1);
    eof = (frame_pair == PPF - 1);
    for (int k = 0; k < 6; k++)
      exp_q.push_back({(k == 5) && eol, (k == 5) && eof, seq[k]});
    frame_pair = (frame_pair + 1) % PPF;
  endtask

  task automatic put_pair(input bit keep);
    rand_data();
    HSYNC = 1'b1;
    if (keep) add_pair(DATA_R0, DATA_G0, DATA_B0, DATA_R1, DATA_G1, DATA_B1);
  endtask

  task automatic send_pairs(input int n, input int gmin, input int gmax, input int nkeep);
    int g;
    for (int i = 0; i < n; i++) begin
      tick();
      put_pair(i < nkeep);
      g = int'($urandom_range(gmax, gmin));
      for (int k = 1; k < g; k++) begin
        tick();
        HSYNC = 1'b0;
      end
    end
    tick();
    HSYNC = 1'b0;
  endtask

  task automatic clear_stream();
    rx_q.delete();
    exp_q.delete();
    rx_cyc.delete();
    fd_cyc.delete();
  endtask

  task automatic compare_stream(input string tag, input int budget);
    int n;
    n = exp_q.size();
    for (int i = 0; i < budget && rx_q.size() < n; i++) @(negedge HCLK);
    repeat (4) @(negedge HCLK);
    #1;
    check({tag, " count"}, rx_q.size(), n);
    for (int i = 0; i < n && i < rx_q.size(); i++)
      check({tag, " byte"}, 32'(rx_q[i]), 32'(exp_q[i]));
  endtask

  task automatic apply_reset(input int n);
    tick();
    HRESET = 1'b1;
    HSYNC  = 1'b0;
    VSYNC  = 1'b0;
    repeat (n) tick();
    HRESET = 1'b0;
    clear_stream();
    frame_pair = 0;
  endtask

  logic [7:0] single_exp [6];

  initial begin
    // Reset with random inputs: everything observable stays zero.
    rand_data();
    HSYNC = 1'($urandom);
    VSYNC = 1'($urandom);
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("reset outputs",
            32'({obus.out_byte, obus.out_valid, obus.out_eol, obus.out_eof,
                 frame_done, overflow, frame_err}), 32'd0);
      tick();
      rand_data();
      HSYNC = 1'($urandom);
      VSYNC = 1'($urandom);
    end
    HRESET = 1'b0;
    HSYNC  = 1'b0;
    VSYNC  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge HCLK);
      check("post-reset valid", 32'(obus.out_valid), 32'd0);
      tick();
    end
    clear_stream();

    // Single pair: fixed bytes, latency two cycles, BMP order.
    single_exp = '{8'h33, 8'h22, 8'h11, 8'h66, 8'h55, 8'h44};
    DATA_R0 = 8'h11; DATA_G0 = 8'h22; DATA_B0 = 8'h33;
    DATA_R1 = 8'h44; DATA_G1 = 8'h55; DATA_B1 = 8'h66;
    HSYNC = 1'b1;
    tick();
    HSYNC = 1'b0;
    @(negedge HCLK);
    check("single latency c1", 32'(obus.out_valid), 32'd0);
    for (int k = 0; k < 6; k++) begin
      tick();
      @(negedge HCLK);
      check("single byte", 32'({obus.out_valid, obus.out_byte}), 32'({1'b1, single_exp[k]}));
    end
    tick();
    @(negedge HCLK);
    check("single end valid", 32'(obus.out_valid), 32'd0);
    apply_reset(2);

    // Full frame back-to-back at full rate.
    send_pairs(4, 1, 1, 4);
    compare_stream("frame", 100);
    if (rx_cyc.size() >= 24) begin
      check("frame contiguous", 32'(rx_cyc[23] - rx_cyc[0]), 32'd23);
      check("frame_done pulses", 32'(fd_cyc.size()), 32'd1);
      if (fd_cyc.size() > 0)
        check("frame_done timing", 32'(fd_cyc[0]), 32'(rx_cyc[23] + 1));
    end
    clear_stream();

    // VSYNC with nothing in progress (and a concurrent HSYNC) is ignored.
    tick();
    rand_data();
    VSYNC = 1'b1;
    HSYNC = 1'b1;
    tick();
    VSYNC = 1'b0;
    HSYNC = 1'b0;
    repeat (8) tick();
    @(negedge HCLK);
    check("idle vsync frame_err", 32'(frame_err), 32'd0);
    check("idle vsync no bytes", 32'(rx_q.size()), 32'd0);
    check("idle vsync valid", 32'(obus.out_valid), 32'd0);

    // Backpressure: fixed 1,0,0,1 pattern, then random ready with spaced pairs.
    rdy_mode = 2;
    send_pairs(4, 1, 1, 4);
    compare_stream("bp pattern", 200);
    clear_stream();
    rdy_mode = 3;
    send_pairs(8, 10, 16, 8);
    compare_stream("bp random", 400);
    check("bp frame_done pulses", 32'(fd_cyc.size()), 32'd2);
    check("bp stall stability", 32'(stall_viol), 32'd0);
    check("bp no overflow", 32'(overflow), 32'd0);
    clear_stream();

    // Overflow: consumer stalled, six pairs, the sixth is dropped.
    rdy_mode = 0;
    repeat (3) tick();
    send_pairs(6, 1, 1, 5);
    repeat (2) tick();
    @(negedge HCLK);
    check("ovf flag", 32'(overflow), 32'd1);
    check("ovf held valid", 32'(obus.out_valid), 32'd1);
    check("ovf nothing yet", 32'(rx_q.size()), 32'd0);
    rdy_mode = 1;
    compare_stream("ovf drain", 120);
    check("ovf sticky", 32'(overflow), 32'd1);
    check("ovf no frame_err", 32'(frame_err), 32'd0);
    apply_reset(2);
    @(negedge HCLK);
    check("ovf cleared by reset", 32'(overflow), 32'd0);

    // VSYNC abort after two pairs, then a clean frame.
    tick();
    put_pair(1'b0);
    tick();
    put_pair(1'b0);
    tick();
    rand_data();
    HSYNC = 1'b1;
    VSYNC = 1'b1;
    @(negedge HCLK);
    check("abort pre valid", 32'(obus.out_valid), 32'd1);
    tick();
    HSYNC = 1'b0;
    VSYNC = 1'b0;
    @(negedge HCLK);
    check("abort valid", 32'(obus.out_valid), 32'd0);
    check("abort frame_err", 32'(frame_err), 32'd1);
    repeat (6) tick();
    @(negedge HCLK);
    check("abort flushed", 32'(obus.out_valid), 32'd0);
    #1;
    clear_stream();
    frame_pair = 0;
    rdy_mode = 3;
    send_pairs(4, 1, 3, 4);
    compare_stream("post-abort frame", 300);
    check("post-abort frame_done", 32'(fd_cyc.size()), 32'd1);
    check("frame_err sticky", 32'(frame_err), 32'd1);
    check("post-abort stall stability", 32'(stall_viol), 32'd0);
    clear_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
